// File: rtl/branch_resolve.sv
// Branch/jump resolution stage: waits for the evaluator's condition, computes the
// target, holds a redirect to fetch until accepted, and flushes younger instructions.
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    input  logic             cond_in,
    input  logic             redirect_ready,
    output logic             busy,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             link_valid,
    output logic [XLEN-1:0]  link_data,
    output logic             misalign,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EVAL     = 2'b01,
        REDIRECT = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] FOUR       = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(1);

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, imm_q, rs1_q;
    logic [1:0]       type_q;
    logic [XLEN-1:0]  tgt_q;
    logic [1:0]       tgt_in_lo;
    logic             accept, jump_mis, branch_mis, count_inc;
    logic             link_valid_q, flush_q, misalign_q;
    logic [XLEN-1:0]  link_data_q;
    logic [CNT_W-1:0] taken_q;

    // The low two target bits depend only on the low two operand bits, so jump
    // alignment is decided at accept time without a full-width adder.
    always_comb begin
        tgt_in_lo = (br_type == 2'b11) ? ((rs1[1:0] + imm[1:0]) & 2'b10)
                                       : (pc[1:0] + imm[1:0]);
        tgt_q     = (type_q == 2'b11) ? ((rs1_q + imm_q) & ALIGN_MASK)
                                      : (pc_q + imm_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        jump_mis   = 1'b0;
        branch_mis = 1'b0;
        count_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (br_valid && (br_type != 2'b00)) begin
                    accept = 1'b1;
                    if (!br_type[1]) begin
                        state_d = EVAL;
                    end else if (tgt_in_lo == 2'b00) begin
                        state_d = REDIRECT;
                    end else begin
                        jump_mis = 1'b1;
                    end
                end
            end
            EVAL: begin
                state_d = IDLE;
                if (cond_in) begin
                    count_inc = 1'b1;
                    if (tgt_q[1:0] == 2'b00) begin
                        state_d = REDIRECT;
                    end else begin
                        branch_mis = 1'b1;
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latches, single-cycle pulses and the taken counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            type_q       <= 2'b00;
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            misalign_q   <= 1'b0;
            flush_q      <= 1'b0;
            taken_q      <= '0;
        end else begin
            if (accept) begin
                pc_q   <= pc;
                imm_q  <= imm;
                rs1_q  <= rs1;
                type_q <= br_type;
            end
            link_valid_q <= accept && br_type[1];
            if (accept && br_type[1]) begin
                link_data_q <= pc + FOUR;
            end
            misalign_q <= jump_mis | branch_mis;
            flush_q    <= (state_d == REDIRECT) && (state_q != REDIRECT);
            if (count_inc) begin
                taken_q <= taken_q + CNT_W'(1);
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = redirect_valid ? tgt_q : '0;
    assign flush          = flush_q;
    assign link_valid     = link_valid_q;
    assign link_data      = link_data_q;
    assign misalign       = misalign_q;
    assign taken_count    = taken_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve, built with a 2-bit taken
// counter so that counter wrap is reachable in a handful of branches.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [31:0] pc, imm, rs1;
    logic        cond_in;
    logic        redirect_ready;
    logic        busy, redirect_valid, flush, link_valid, misalign;
    logic [31:0] redirect_pc, link_data;
    logic [1:0]  taken_count;

    int compared;
    int mismatched;
    logic [1:0] exp_count;

    branch_resolve #(.XLEN(32), .CNT_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .br_valid      (br_valid),
        .br_type       (br_type),
        .pc            (pc),
        .imm           (imm),
        .rs1           (rs1),
        .cond_in       (cond_in),
        .redirect_ready(redirect_ready),
        .busy          (busy),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .link_valid    (link_valid),
        .link_data     (link_data),
        .misalign      (misalign),
        .taken_count   (taken_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] t,
                                 input logic [31:0] p, input logic [31:0] i,
                                 input logic [31:0] r);
        br_valid = v;
        br_type  = t;
        pc       = p;
        imm      = i;
        rs1      = r;
    endtask

    task automatic test_reset;
        #3;
        if ({busy, redirect_valid, flush, link_valid, misalign} !== 5'b00000) begin
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {busy, redirect_valid, flush, link_valid, misalign});
            mismatched++;
        end
        compared++;
        if ({redirect_pc, link_data} !== 64'h0) begin
            $display("[TB] FAIL reset_data: got %h/%h expected 0/0", redirect_pc, link_data);
            mismatched++;
        end
        compared++;
        if (taken_count !== 2'd0) begin
            $display("[TB] FAIL reset_count: got %0d expected 0", taken_count);
            mismatched++;
        end
        compared++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_count = 2'd0;
    endtask

    task automatic test_taken_branch;
        redirect_ready = 1'b1;
        cond_in = 1'b0;
        applyStimulus(1'b1, 2'b01, 32'h0000_0200, 32'hFFFF_FFF0, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        if ({busy, redirect_valid, flush} !== 3'b100) begin
            $display("[TB] FAIL taken_eval: got %b expected 100", {busy, redirect_valid, flush});
            mismatched++;
        end
        compared++;
        cond_in = 1'b1;
        tick();
        cond_in = 1'b0;
        exp_count = exp_count + 2'd1;
        if ({redirect_valid, flush} !== 2'b11 || redirect_pc !== 32'h0000_01F0) begin
            $display("[TB] FAIL taken_redirect: got v/f=%b pc=%h expected 11 pc=000001f0",
                     {redirect_valid, flush}, redirect_pc);
            mismatched++;
        end
        compared++;
        if (taken_count !== exp_count) begin
            $display("[TB] FAIL taken_count: got %0d expected %0d", taken_count, exp_count);
            mismatched++;
        end
        compared++;
        tick();
        if ({busy, redirect_valid, flush} !== 3'b000) begin
            $display("[TB] FAIL taken_done: got %b expected 000", {busy, redirect_valid, flush});
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_not_taken;
        cond_in = 1'b0;
        applyStimulus(1'b1, 2'b01, 32'h0000_0300, 32'h0000_0020, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        if ({busy, redirect_valid, flush} !== 3'b100) begin
            $display("[TB] FAIL nottaken_eval: got %b expected 100", {busy, redirect_valid, flush});
            mismatched++;
        end
        compared++;
        tick();
        if ({busy, redirect_valid, flush, misalign} !== 4'b0000 || taken_count !== exp_count) begin
            $display("[TB] FAIL nottaken_done: got %b cnt=%0d expected 0000 cnt=%0d",
                     {busy, redirect_valid, flush, misalign}, taken_count, exp_count);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_jalr_backpressure;
        redirect_ready = 1'b0;
        applyStimulus(1'b1, 2'b11, 32'h0000_0400, 32'h0000_0005, 32'h0000_1003);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        if (link_data !== 32'h0000_0404) begin
            $display("[TB] FAIL jalr_link_data: got %h expected 00000404", link_data);
            mismatched++;
        end
        compared++;
        for (int i = 0; i < 4; i++) begin
            redirect_ready = (i == 3);
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_1008) begin
                $display("[TB] FAIL jalr_hold%0d: got v=%b pc=%h expected 1 00001008",
                         i, redirect_valid, redirect_pc);
                mismatched++;
            end
            compared++;
            if (flush !== (i == 0) || link_valid !== (i == 0)) begin
                $display("[TB] FAIL jalr_pulse%0d: got flush=%b link=%b expected %b",
                         i, flush, link_valid, (i == 0));
                mismatched++;
            end
            compared++;
            tick();
        end
        if ({busy, redirect_valid} !== 2'b00) begin
            $display("[TB] FAIL jalr_release: got %b expected 00", {busy, redirect_valid});
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_misaligned;
        redirect_ready = 1'b1;
        applyStimulus(1'b1, 2'b10, 32'h0000_0000, 32'h0000_0006, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        if ({misalign, link_valid, redirect_valid, flush, busy} !== 5'b11000 ||
            link_data !== 32'h0000_0004) begin
            $display("[TB] FAIL misalign_jal: got %b link=%h expected 11000 link=00000004",
                     {misalign, link_valid, redirect_valid, flush, busy}, link_data);
            mismatched++;
        end
        compared++;
        tick();
        if ({misalign, link_valid} !== 2'b00) begin
            $display("[TB] FAIL misalign_jal_end: got %b expected 00", {misalign, link_valid});
            mismatched++;
        end
        compared++;
        applyStimulus(1'b1, 2'b01, 32'h0000_0010, 32'h0000_0002, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        cond_in = 1'b1;
        tick();
        cond_in = 1'b0;
        exp_count = exp_count + 2'd1;
        if ({misalign, redirect_valid, flush, busy} !== 4'b1000 || taken_count !== exp_count) begin
            $display("[TB] FAIL misalign_br: got %b cnt=%0d expected 1000 cnt=%0d",
                     {misalign, redirect_valid, flush, busy}, taken_count, exp_count);
            mismatched++;
        end
        compared++;
        tick();
    endtask

    task automatic test_back_to_back;
        redirect_ready = 1'b1;
        cond_in = 1'b0;
        applyStimulus(1'b1, 2'b01, 32'h0000_0600, 32'h0000_0020, 32'h0);
        tick();
        applyStimulus(1'b1, 2'b10, 32'h0000_0700, 32'h0000_0010, 32'h0);
        tick();
        if ({busy, link_valid, redirect_valid} !== 3'b000) begin
            $display("[TB] FAIL b2b_ignored: got %b expected 000", {busy, link_valid, redirect_valid});
            mismatched++;
        end
        compared++;
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        if ({link_valid, redirect_valid} !== 2'b11 || link_data !== 32'h0000_0704 ||
            redirect_pc !== 32'h0000_0710) begin
            $display("[TB] FAIL b2b_accept: got %b link=%h pc=%h expected 11 00000704 00000710",
                     {link_valid, redirect_valid}, link_data, redirect_pc);
            mismatched++;
        end
        compared++;
        tick();
        if (busy !== 1'b0) begin
            $display("[TB] FAIL b2b_done: got busy=%b expected 0", busy);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_link_wrap;
        redirect_ready = 1'b1;
        applyStimulus(1'b1, 2'b10, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        if (link_valid !== 1'b1 || link_data !== 32'h0000_0000 || redirect_pc !== 32'h0000_0004) begin
            $display("[TB] FAIL link_wrap: got lv=%b link=%h pc=%h expected 1 00000000 00000004",
                     link_valid, link_data, redirect_pc);
            mismatched++;
        end
        compared++;
        tick();
    endtask

    task automatic test_reset_mid_redirect;
        redirect_ready = 1'b0;
        applyStimulus(1'b1, 2'b10, 32'h0000_0100, 32'h0000_0040, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0140 || link_data !== 32'h0000_0104) begin
            $display("[TB] FAIL midrst_pre: got v=%b pc=%h link=%h expected 1 00000140 00000104",
                     redirect_valid, redirect_pc, link_data);
            mismatched++;
        end
        compared++;
        tick();
        rst_n = 1'b0;
        #1;
        if ({busy, redirect_valid, flush, link_valid, misalign} !== 5'b00000 ||
            {redirect_pc, link_data} !== 64'h0 || taken_count !== 2'd0) begin
            $display("[TB] FAIL midrst_outputs: got %b pc=%h link=%h cnt=%0d expected all 0",
                     {busy, redirect_valid, flush, link_valid, misalign}, redirect_pc,
                     link_data, taken_count);
            mismatched++;
        end
        compared++;
        exp_count = 2'd0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({busy, flush, redirect_valid} !== 3'b000) begin
                $display("[TB] FAIL midrst_after%0d: got %b expected 000", i, {busy, flush, redirect_valid});
                mismatched++;
            end
            compared++;
        end
    endtask

    task automatic test_counter_wrap;
        redirect_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 2'b01, 32'h0000_0800, 32'h0000_0040, 32'h0);
            tick();
            applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
            cond_in = 1'b1;
            tick();
            cond_in = 1'b0;
            tick();
            if (k == 3) begin
                if (taken_count !== 2'd3) begin
                    $display("[TB] FAIL count_three: got %0d expected 3", taken_count);
                    mismatched++;
                end
                compared++;
            end
        end
        if (taken_count !== 2'd0) begin
            $display("[TB] FAIL count_wrap: got %0d expected 0", taken_count);
            mismatched++;
        end
        compared++;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        exp_count = 2'd0;
        rst_n = 1'b0;
        cond_in = 1'b0;
        redirect_ready = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_taken_branch();
        test_not_taken();
        test_jalr_backpressure();
        test_misaligned();
        test_back_to_back();
        test_link_wrap();
        test_reset_mid_redirect();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Control stage directly downstream of the branch condition evaluator.
- Captures a decoded branch/jump from execute and waits one cycle for the evaluator's registered condition result.
- Computes the target, drives a held redirect to fetch until acknowledged, and flushes the younger instructions already fetched.
- Also produces the jump link value and a taken-branch counter.

Parameters:
XLEN, 32, data/address width
CNT_W, 16, width of taken-branch counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
br_valid  in  1  execute presents a control-flow instruction this cycle
br_type  in  2  00 none, 01 conditional branch, 10 JAL, 11 JALR
pc  in  XLEN  PC of the instruction
imm  in  XLEN  sign-extended immediate
rs1  in  XLEN  rs1 value (JALR base)
cond_in  in  1  condition from the evaluator, valid the cycle after the operands were presented
redirect_ready  in  1  fetch accepts redirect
busy  out  1  stall request to execute; high in any state other than IDLE
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  XLEN  redirect target
flush  out  1  one-cycle pulse: kill younger instructions
link_valid  out  1  one-cycle pulse: link_data is to be written to rd
link_data  out  XLEN  pc+4 of the jump
misalign  out  1  one-cycle pulse: target not 4-byte aligned
taken_count  out  CNT_W  number of taken conditional branches

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State is IDLE.
  - All outputs are 0, including redirect_pc, link_data and taken_count.
  - Latched pc, imm and rs1 are cleared.
  - Reset in any state, including mid-REDIRECT, abandons the pending redirect; no flush is issued.
- States: IDLE, EVAL, REDIRECT.
- IDLE, accept condition is br_valid=1 and br_type!=00. On accept, latch pc, imm, rs1 and br_type.
  - br_type=01: compute tgt=pc+imm; go to EVAL.
  - br_type=10: tgt=pc+imm.
  - br_type=11: tgt=(rs1+imm) with bit0 cleared.
  - For 10 and 11, on the next cycle: link_valid=1, link_data=pc+4, then go to REDIRECT.
  - br_valid with br_type=00 is ignored.
- EVAL (exactly 1 cycle): sample cond_in.
  - cond_in=1: increment taken_count, wrapping modulo 2^CNT_W; go to REDIRECT.
  - cond_in=0: go to IDLE, no redirect (the fall-through path is already fetched).
- REDIRECT:
  - redirect_valid=1 and redirect_pc=tgt, both held stable until redirect_ready=1.
  - flush=1 on the first REDIRECT cycle only.
  - When redirect_valid and redirect_ready are both 1 in the same cycle: next state IDLE, redirect_valid drops the following cycle.
  - redirect_ready already high on entry means the redirect lasts exactly 1 cycle.
- Alignment:
  - If tgt[1:0]!=00 when REDIRECT would be entered, do not enter it.
  - Instead pulse misalign=1 for one cycle, return to IDLE, and issue no redirect or flush.
  - For a taken branch, taken_count still increments.
  - For a jump, link_valid is still issued.
- Arithmetic: all additions are XLEN-bit modulo 2^XLEN; carry out is discarded; pc+4 wraps at 0xFFFFFFFC->0x00000000.
- Latency from accept to redirect_valid:
  - Branch: 2 cycles.
  - Jump: 1 cycle.
- Stall protocol:
  - busy=1 in EVAL and REDIRECT.
  - Execute holds its instruction while busy; br_valid seen while busy is ignored.
  - The next instruction can be accepted in the same cycle the FSM returns to IDLE.

Test Plan:
- Reset mid-REDIRECT: JAL pc=0x100 imm=0x40 with redirect_ready=0, assert rst_n=0 after 2 cycles -> all outputs 0 immediately; after release, busy=0 and no flush ever issued.
- Taken BEQ: pc=0x200, imm=0xFFFFFFF0, cond_in=1 in the EVAL cycle, redirect_ready=1 -> redirect_pc=0x1F0 two cycles after accept; flush for 1 cycle; taken_count=1.
- Not-taken branch: pc=0x300, imm=0x20, cond_in=0 -> no redirect_valid and no flush; busy high 1 cycle; taken_count unchanged.
- JALR with backpressure: rs1=0x1003, imm=0x5, redirect_ready low for 3 cycles -> link_data=pc+4 pulsed once; redirect_pc=0x1008 held 4 cycles; flush only on the first of them.
- Misaligned JAL: pc=0x0, imm=0x6 -> misalign pulse, link_valid pulse, no redirect; back in IDLE after 1 cycle.
- Counter wrap and wrap-around: CNT_W=2, 4 taken branches -> taken_count=0; JAL at pc=0xFFFFFFFC -> link_data=0x00000000.
